fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage of the KNIPS core. It sits directly upstream of the control decoder: it holds the PC that addresses the instruction ROM, and it consumes the decoder's `jump_en` and `branch_en` to choose the next PC. It also owns run/halt sequencing (start, stall, halt, done) and a retired-cycle counter that the testbench reads for performance figures.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit_jump_lut.sv | 17 +
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the KNIPS fetch stage: FSM state type, default PC width
// and the jump-target table used by the jump LUT.
package definitions;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam int PC_W_DEFAULT = 10;

   // Entries 8..15 have no assigned target and read back as 0.
   localparam int unsigned JUMP_TARGETS [16] = '{
      0, 40, 64, 100, 200, 300, 512, 1000,
      0, 0, 0, 0, 0, 0, 0, 0
   };

endpackage

// File: rtl/fetch_unit_if.sv
// Control/status bundle between the sequencing environment (master) and the
// fetch unit (slave).
interface fetch_unit_if
   import definitions::*;
#(
   parameter int PC_W  = PC_W_DEFAULT,
   parameter int CNT_W = 16
);
   logic             Start;
   logic [PC_W-1:0]  StartAddr;
   logic             Stall;
   logic             Halt_req;
   logic             jump_en;
   logic             branch_en;
   logic [3:0]       TargetIdx;
   logic [PC_W-1:0]  PC;
   logic             Fetch_valid;
   logic             Done;
   logic [CNT_W-1:0] Cycles;

   modport master (
      output Start, StartAddr, Stall, Halt_req, jump_en, branch_en, TargetIdx,
      input  PC, Fetch_valid, Done, Cycles
   );

   modport slave (
      input  Start, StartAddr, Stall, Halt_req, jump_en, branch_en, TargetIdx,
      output PC, Fetch_valid, Done, Cycles
   );
endinterface

// File: rtl/fetch_unit_jump_lut.sv
// Combinational 16-entry jump-target ROM indexed by instruction bits [8:5].
module jump_lut
   import definitions::*;
#(
   parameter int PC_W = PC_W_DEFAULT
) (
   input  logic [3:0]      TargetIdx,
   output logic [PC_W-1:0] target
);
   logic [PC_W-1:0] rom [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_rom
      assign rom[gi] = PC_W'(JUMP_TARGETS[gi]);
   end

   assign target = rom[TargetIdx];
endmodule

// File: rtl/fetch_unit.sv
// KNIPS fetch stage: PC register, next-PC selection, run/halt sequencing and a
// saturating count of RUN cycles.
module fetch_unit
   import definitions::*;
#(
   parameter int              PC_W      = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] LAST_ADDR = '1,
   parameter int              CNT_W     = 16
) (
   input  logic          CLK,
   input  logic          Reset,
   fetch_unit_if.slave   fetch
);
   fetch_state_t     state_reg;
   logic [PC_W-1:0]  pc_reg;
   logic [CNT_W-1:0] cycles_reg;
   logic             fetch_valid_reg;
   logic             done_reg;

   logic [PC_W-1:0]  jump_target;
   logic [PC_W-1:0]  branch_target;

   jump_lut #(.PC_W(PC_W)) u_jump_lut (
      .TargetIdx (fetch.TargetIdx),
      .target    (jump_target)
   );

   // Offset is a signed 4-bit field; the sum wraps modulo 2**PC_W.
   assign branch_target = pc_reg + {{(PC_W-4){fetch.TargetIdx[3]}}, fetch.TargetIdx};

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_reg       <= IDLE;
         pc_reg          <= '0;
         cycles_reg      <= '0;
         fetch_valid_reg <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, HALTED: begin
               if (fetch.Start) begin
                  state_reg       <= RUN;
                  pc_reg          <= fetch.StartAddr;
                  cycles_reg      <= '0;
                  fetch_valid_reg <= 1'b1;
                  done_reg        <= 1'b0;
               end
            end
            RUN: begin
               if (cycles_reg != '1)
                  cycles_reg <= cycles_reg + CNT_W'(1);
               if (fetch.Halt_req) begin
                  state_reg       <= HALTED;
                  fetch_valid_reg <= 1'b0;
                  done_reg        <= 1'b1;
               end else if (fetch.Stall) begin
                  pc_reg <= pc_reg;
               end else if (fetch.jump_en) begin
                  pc_reg <= jump_target;
               end else if (fetch.branch_en) begin
                  pc_reg <= branch_target;
               end else if (pc_reg == LAST_ADDR) begin
                  // Natural end of program: stop rather than wrap to 0.
                  state_reg       <= HALTED;
                  fetch_valid_reg <= 1'b0;
                  done_reg        <= 1'b1;
               end else begin
                  pc_reg <= pc_reg + PC_W'(1);
               end
            end
            default: begin
               state_reg       <= IDLE;
               fetch_valid_reg <= 1'b0;
               done_reg        <= 1'b0;
            end
         endcase
      end
   end

   assign fetch.PC          = pc_reg;
   assign fetch.Fetch_valid = fetch_valid_reg;
   assign fetch.Done        = done_reg;
   assign fetch.Cycles      = cycles_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: hand-computed PC, status and cycle counts.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   fetch_unit_if #(.PC_W(10), .CNT_W(16)) fetch ();

   fetch_unit #(.PC_W(10), .LAST_ADDR(10'd1023), .CNT_W(16)) dut (
      .CLK   (clk),
      .Reset (rst),
      .fetch (fetch)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: got=%0d", tag, got);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      fetch.Start     = 1'b0;
      fetch.Stall     = 1'b0;
      fetch.Halt_req  = 1'b0;
      fetch.jump_en   = 1'b0;
      fetch.branch_en = 1'b0;
      fetch.TargetIdx = 4'd0;
   endtask

   // Asynchronous reset pulse between edges, then a Start at addr.
   task automatic restart(input logic [9:0] addr);
      clear_ctl();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      fetch.Start     = 1'b1;
      fetch.StartAddr = addr;
      step();
      fetch.Start = 1'b0;
   endtask

   task automatic one_ctl(input string tag, input logic [9:0] start_pc,
                          input logic j, input logic b, input logic [3:0] idx,
                          input logic [9:0] exp_pc);
      restart(start_pc);
      fetch.jump_en   = j;
      fetch.branch_en = b;
      fetch.TargetIdx = idx;
      step();
      clear_ctl();
      check(tag, 32'(fetch.PC), 32'(exp_pc));
   endtask

   initial begin
      clear_ctl();
      fetch.StartAddr = '0;
      step(2);
      check("rst_pc",     32'(fetch.PC), 0);
      check("rst_valid",  32'(fetch.Fetch_valid), 0);
      check("rst_done",   32'(fetch.Done), 0);
      check("rst_cycles", 32'(fetch.Cycles), 0);
      rst = 1'b0;

      // Inputs other than Start are ignored in IDLE.
      fetch.jump_en = 1'b1; fetch.TargetIdx = 4'd3;
      step();
      check("idle_ignore_pc", 32'(fetch.PC), 0);
      clear_ctl();

      fetch.Start = 1'b1; fetch.StartAddr = 10'd5;
      step();
      fetch.Start = 1'b0;
      check("start_pc",     32'(fetch.PC), 5);
      check("start_valid",  32'(fetch.Fetch_valid), 1);
      check("start_cycles", 32'(fetch.Cycles), 0);
      step(3);
      check("run3_pc",     32'(fetch.PC), 8);
      check("run3_cycles", 32'(fetch.Cycles), 3);

      one_ctl("jump_idx3",     10'd20, 1'b1, 1'b0, 4'd3,     10'd100);
      one_ctl("jump_over_br",  10'd20, 1'b1, 1'b1, 4'd3,     10'd100);
      one_ctl("jump_idx7",     10'd20, 1'b1, 1'b0, 4'd7,     10'd1000);
      one_ctl("jump_undef",    10'd20, 1'b1, 1'b0, 4'd12,    10'd0);
      one_ctl("branch_m3",     10'd20, 1'b0, 1'b1, 4'b1101,  10'd17);
      one_ctl("branch_p7",     10'd20, 1'b0, 1'b1, 4'b0111,  10'd27);
      one_ctl("branch_m8",     10'd20, 1'b0, 1'b1, 4'b1000,  10'd12);
      one_ctl("branch_wrap",   10'd2,  1'b0, 1'b1, 4'b1101,  10'd1023);

      // Stall holds PC while the counter keeps running; halt then freezes both.
      restart(10'd9);
      fetch.Stall = 1'b1;
      fetch.jump_en = 1'b1; fetch.TargetIdx = 4'd3;
      step(4);
      check("stall_pc",     32'(fetch.PC), 9);
      check("stall_cycles", 32'(fetch.Cycles), 4);
      fetch.Halt_req = 1'b1;
      step();
      clear_ctl();
      check("halt_done",   32'(fetch.Done), 1);
      check("halt_valid",  32'(fetch.Fetch_valid), 0);
      check("halt_pc",     32'(fetch.PC), 9);
      check("halt_cycles", 32'(fetch.Cycles), 5);
      fetch.jump_en = 1'b1; fetch.TargetIdx = 4'd3;
      step(10);
      clear_ctl();
      check("frozen_pc",     32'(fetch.PC), 9);
      check("frozen_cycles", 32'(fetch.Cycles), 5);
      check("frozen_done",   32'(fetch.Done), 1);

      // Restart from HALTED, then Start while running is ignored.
      fetch.Start = 1'b1; fetch.StartAddr = 10'd30;
      step();
      check("restart_pc",     32'(fetch.PC), 30);
      check("restart_done",   32'(fetch.Done), 0);
      check("restart_cycles", 32'(fetch.Cycles), 0);
      fetch.StartAddr = 10'd500;
      step();
      fetch.Start = 1'b0;
      check("start_in_run_pc", 32'(fetch.PC), 31);

      // Halt beats jump.
      fetch.Halt_req = 1'b1; fetch.jump_en = 1'b1; fetch.TargetIdx = 4'd3;
      step();
      clear_ctl();
      check("halt_prio_pc",   32'(fetch.PC), 31);
      check("halt_prio_done", 32'(fetch.Done), 1);

      // Natural end of program at LAST_ADDR.
      restart(10'd1022);
      check("end_start_pc", 32'(fetch.PC), 1022);
      step();
      check("end_last_pc",   32'(fetch.PC), 1023);
      check("end_last_done", 32'(fetch.Done), 0);
      step();
      check("end_done",  32'(fetch.Done), 1);
      check("end_pc",    32'(fetch.PC), 1023);
      step(3);
      check("end_hold_pc", 32'(fetch.PC), 1023);

      // Reset between edges mid-RUN.
      restart(10'd40);
      step(2);
      check("pre_rst_pc", 32'(fetch.PC), 42);
      rst = 1'b1;
      #2;
      check("async_rst_pc",     32'(fetch.PC), 0);
      check("async_rst_valid",  32'(fetch.Fetch_valid), 0);
      check("async_rst_cycles", 32'(fetch.Cycles), 0);
      check("async_rst_done",   32'(fetch.Done), 0);
      rst = 1'b0;
      step(3);
      check("no_start_pc",    32'(fetch.PC), 0);
      check("no_start_valid", 32'(fetch.Fetch_valid), 0);
      fetch.Start = 1'b1; fetch.StartAddr = 10'd7;
      step();
      fetch.Start = 1'b0;
      check("resume_pc", 32'(fetch.PC), 7);

      // Counter saturation under a long stall.
      restart(10'd0);
      fetch.Stall = 1'b1;
      step(65540);
      check("sat_cycles", 32'(fetch.Cycles), 65535);
      check("sat_pc",     32'(fetch.PC), 0);
      clear_ctl();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
